avl_bus_wrr_arb: RTL and testbench

Weighted round-robin, burst-aware arbiter that selects which of `MASTER_NUM` Avalon requesters drives the shared downstream command port of an N-to-1 bus mux. It tracks write bursts so the selected master is never switched mid-burst. It enforces a per-master command quota (weight) before rotating. Its `sel` output drives the command multiplexer and the response-routing FIFO of the N-to-1 bus.

---
 rtl/avl_bus_wrr_arb.sv | 129 ++++++++++++
 tb/tb_avl_bus_wrr_arb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_bus_wrr_arb.sv
// Weighted round-robin, burst-aware command arbiter for an N-to-1 Avalon mux.
// Holds the grant across multi-beat write bursts and rotates after each master's quota.
module avl_bus_wrr_arb #(
  parameter int  MASTER_NUM   = 4,
  parameter int  WEIGHT_WIDTH = 4,
  parameter int  BURST_WIDTH  = 8,
  localparam int SEL_WIDTH    = $clog2(MASTER_NUM)
) (
  input  logic                               clk,
  input  logic                               rest,
  input  logic [MASTER_NUM-1:0]              request,
  input  logic [MASTER_NUM*WEIGHT_WIDTH-1:0] weight,
  input  logic                               cmd_read,
  input  logic                               cmd_write,
  input  logic                               cmd_begin_burst,
  input  logic [BURST_WIDTH-1:0]             cmd_burst_count,
  input  logic                               request_ready,
  output logic [SEL_WIDTH-1:0]               sel,
  output logic                               locked
);

  typedef enum logic {
    ARB,
    WBURST
  } state_e;

  state_e                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [WEIGHT_WIDTH-1:0] used_q, used_d;
  logic [BURST_WIDTH-1:0]  beats_q, beats_d;

  logic [WEIGHT_WIDTH-1:0] wt_arr [MASTER_NUM];
  logic [WEIGHT_WIDTH-1:0] quota;
  logic                    exhausted;
  logic                    acc;
  logic                    start_burst;
  logic                    complete;
  logic                    rot;
  logic [SEL_WIDTH-1:0]    nxt;
  logic                    found;
  int                      idx;

  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_wt
    assign wt_arr[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  assign quota = (wt_arr[sel_q] == '0)
               ? WEIGHT_WIDTH'(1) : wt_arr[sel_q];

  // Extra bit so used+1 cannot wrap at the top weight value.
  assign exhausted =
    ({1'b0, used_q} + (WEIGHT_WIDTH+1)'(1)) >= {1'b0, quota};

  assign acc = (cmd_read | cmd_write) & request_ready;

  assign start_burst = acc & cmd_write & cmd_begin_burst
                     & (cmd_burst_count > BURST_WIDTH'(1));

  // Scan from sel+1 around to sel itself.
  always_comb begin
    nxt   = sel_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      idx = (int'(sel_q) + k) % MASTER_NUM;
      if (!found && request[idx]) begin
        found = 1'b1;
        nxt   = SEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    used_d   = used_q;
    beats_d  = beats_q;
    complete = 1'b0;
    rot      = 1'b0;
    unique case (state_q)
      ARB: begin
        if (start_burst) begin
          state_d = WBURST;
          beats_d = cmd_burst_count - BURST_WIDTH'(1);
        end else if (acc) begin
          complete = 1'b1;
        end else if (!request[sel_q] && |request) begin
          rot = 1'b1;
        end
      end
      WBURST: begin
        if (cmd_write && request_ready) begin
          beats_d = beats_q - BURST_WIDTH'(1);
          if (beats_q == BURST_WIDTH'(1)) begin
            state_d  = ARB;
            complete = 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
    if (complete) begin
      if (exhausted) rot = 1'b1;
      else           used_d = used_q + WEIGHT_WIDTH'(1);
    end
    if (rot && |request) begin
      sel_d  = nxt;
      used_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= ARB;
      sel_q   <= '0;
      used_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      used_q  <= used_d;
      beats_q <= beats_d;
    end
  end

  assign sel    = sel_q;
  assign locked = (state_q == WBURST);

endmodule

// File: tb/tb_avl_bus_wrr_arb.sv
// Scoreboard bench for avl_bus_wrr_arb: directed scenarios with fixed
// expectations, then random traffic against a behavioural model.
module tb_avl_bus_wrr_arb;

  logic        clk;
  logic        rest;
  logic [3:0]  request;
  logic [15:0] weight;
  logic        cmd_read;
  logic        cmd_write;
  logic        cmd_begin_burst;
  logic [7:0]  cmd_burst_count;
  logic        request_ready;
  logic [1:0]  sel;
  logic        locked;

  avl_bus_wrr_arb #(
    .MASTER_NUM  (4),
    .WEIGHT_WIDTH(4),
    .BURST_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rest           (rest),
    .request        (request),
    .weight         (weight),
    .cmd_read       (cmd_read),
    .cmd_write      (cmd_write),
    .cmd_begin_burst(cmd_begin_burst),
    .cmd_burst_count(cmd_burst_count),
    .request_ready  (request_ready),
    .sel            (sel),
    .locked         (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    s;
    bit    l;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: current grant, commands used, beats left, burst lock.
  int m_sel, m_used, m_beats;
  bit m_lock;

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (int'(sel) != e.s || locked != e.l) begin
        n_fail++;
        $display("FAIL %s: got sel=%0d locked=%0d, expected sel=%0d locked=%0d",
                 e.tag, sel, locked, e.s, e.l);
      end
    end
  end

  task automatic drive(input logic rst, input logic [3:0] req,
                       input logic [15:0] wt, input logic rd,
                       input logic wr, input logic bb,
                       input logic [7:0] bc, input logic rdy,
                       input int es, input bit el, input string tag);
    exp_t e;
    @(negedge clk);
    rest            = rst;
    request         = req;
    weight          = wt;
    cmd_read        = rd;
    cmd_write       = wr;
    cmd_begin_burst = bb;
    cmd_burst_count = bc;
    request_ready   = rdy;
    e.tag = tag;
    e.s   = es;
    e.l   = el;
    q.push_back(e);
  endtask

  task automatic rotate_to_next(input logic [3:0] req);
    if (req != 0) begin
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_sel + k) % 4;
        if (req[j]) begin
          m_sel = j;
          break;
        end
      end
      m_used = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] req, input logic [15:0] wt,
                            input logic rd, input logic wr, input logic bb,
                            input int bc, input logic rdy);
    bit acc, done, rot;
    int w;
    acc  = (rd | wr) & rdy;
    done = 0;
    rot  = 0;
    if (m_lock) begin
      if (wr && rdy) begin
        m_beats--;
        if (m_beats == 0) begin
          m_lock = 0;
          done   = 1;
        end
      end
    end else if (acc && wr && bb && bc > 1) begin
      m_lock  = 1;
      m_beats = bc - 1;
    end else if (acc) begin
      done = 1;
    end else if (!req[m_sel] && req != 0) begin
      rot = 1;
    end
    if (done) begin
      w = (int'(wt) >> (4 * m_sel)) & 15;
      if (w == 0) w = 1;
      if (m_used + 1 >= w) rot = 1;
      else m_used++;
    end
    if (rot) rotate_to_next(req);
  endtask

  task automatic rnd_cycle();
    exp_t e;
    @(negedge clk);
    rest = 1'b1;
    if ($urandom_range(15) == 0) weight = 16'($urandom);
    request = 4'($urandom);
    if (m_lock) begin
      cmd_read        = 1'b0;
      cmd_write       = ($urandom_range(3) != 0);
      cmd_begin_burst = 1'b0;
      cmd_burst_count = 8'($urandom_range(7));
      request_ready   = 1'($urandom_range(1));
    end else if (request[m_sel]) begin
      cmd_write       = 1'($urandom_range(1));
      cmd_read        = !cmd_write;
      cmd_begin_burst = 1'($urandom_range(1));
      cmd_burst_count = 8'($urandom_range(5));
      request_ready   = ($urandom_range(3) != 0);
    end else begin
      cmd_read        = 1'b0;
      cmd_write       = 1'b0;
      cmd_begin_burst = 1'b0;
      cmd_burst_count = 8'd0;
      request_ready   = 1'($urandom_range(1));
    end
    model_step(request, weight, cmd_read, cmd_write,
               cmd_begin_burst, int'(cmd_burst_count), request_ready);
    e.tag = "random";
    e.s   = m_sel;
    e.l   = m_lock;
    q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrr_exp[8];
    wrr_exp = '{1, 1, 2, 2, 2, 3, 0, 1};
    rest            = 1'b0;
    request         = '0;
    weight          = 16'h1111;
    cmd_read        = 1'b0;
    cmd_write       = 1'b0;
    cmd_begin_burst = 1'b0;
    cmd_burst_count = '0;
    request_ready   = 1'b0;

    drive(0, 4'b0000, 16'h1111, 0, 0, 0, 0, 0, 0, 0, "reset");
    drive(1, 4'b0000, 16'h1111, 0, 0, 0, 0, 0, 0, 0, "reset_idle");

    // weights {1,2,3,1}, all requesting, single reads
    for (int i = 0; i < 8; i++)
      drive(1, 4'b1111, 16'h1321, 1, 0, 0, 1, 1, wrr_exp[i], 0, "wrr_seq");

    // write burst of 4 from master 1, ready 1,0,1,1,0,1
    drive(1, 4'b0110, 16'h1111, 0, 1, 1, 4, 1, 1, 1, "wb_start");
    drive(1, 4'b0100, 16'h1111, 1, 0, 0, 4, 0, 1, 1, "wb_hold_req");
    drive(1, 4'b0110, 16'h1111, 0, 1, 0, 4, 1, 1, 1, "wb_beat2");
    drive(1, 4'b0110, 16'h1111, 0, 1, 0, 4, 1, 1, 1, "wb_beat3");
    drive(1, 4'b0110, 16'h1111, 0, 1, 0, 4, 0, 1, 1, "wb_stall");
    drive(1, 4'b0110, 16'h1111, 0, 1, 0, 4, 1, 2, 0, "wb_end");

    // idle rotation and wrap-around
    drive(1, 4'b1000, 16'h1111, 0, 0, 0, 0, 0, 3, 0, "idle_rot");
    drive(1, 4'b0001, 16'h1111, 0, 0, 0, 0, 0, 0, 0, "idle_wrap");
    drive(1, 4'b0000, 16'h1111, 0, 0, 0, 0, 0, 0, 0, "idle_hold");
    drive(1, 4'b0000, 16'h1111, 0, 0, 0, 0, 0, 0, 0, "idle_hold2");

    // weight 0 and burst_count 0: one single write, then rotate
    drive(1, 4'b0101, 16'h1110, 0, 1, 1, 0, 1, 2, 0, "w0_bc0");

    // read burst counts as one command against weight 2
    drive(1, 4'b0101, 16'h1211, 1, 0, 1, 8, 1, 2, 0, "rd_burst");
    drive(1, 4'b0101, 16'h1211, 1, 0, 0, 1, 1, 0, 0, "rd_burst_rot");

    // single-beat begin_burst write stays unlocked
    drive(1, 4'b0011, 16'h1212, 0, 1, 1, 1, 1, 0, 0, "bc1");
    drive(1, 4'b0011, 16'h1212, 0, 1, 0, 1, 1, 1, 0, "bc1_rot");

    // reset asserted mid-burst with 5 beats left and used=1
    drive(1, 4'b0011, 16'h1222, 1, 0, 0, 1, 1, 1, 0, "pre_rst_rd");
    drive(1, 4'b0011, 16'h1222, 0, 1, 1, 6, 1, 1, 1, "pre_rst_burst");
    drive(0, 4'b0011, 16'h1222, 0, 1, 0, 6, 1, 0, 0, "mid_rst");
    drive(1, 4'b1111, 16'h2222, 1, 0, 0, 1, 1, 0, 0, "post_rst_used");
    drive(1, 4'b1111, 16'h2222, 1, 0, 0, 1, 1, 1, 0, "post_rst_rot");

    // random traffic against the model
    drive(0, 4'b0000, 16'h1111, 0, 0, 0, 0, 0, 0, 0, "rnd_reset");
    m_sel   = 0;
    m_used  = 0;
    m_beats = 0;
    m_lock  = 0;
    weight  = 16'h1111;
    for (int i = 0; i < 3000; i++) rnd_cycle();

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
